// File: rtl/leg_bus_pkg.sv
// Shared bus definitions for the data-memory initiators: transfer-size
// encodings, the burst master state set and the default block length.
package leg_bus_pkg;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int BLOCK_WORDS_DFLT = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SINGLE   = 3'd1,
        ST_BURST_RD = 3'd2,
        ST_BURST_WR = 3'd3,
        ST_RESP     = 3'd4
    } mst_state_e;

endpackage

// File: rtl/lane_align.sv
// Byte-lane handling for a 32-bit little-endian bus: write-data replication,
// read-data extraction with zero extension, and the size/alignment legality
// check. Purely combinational so any initiator can reuse it.
module lane_align
    import leg_bus_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        bad_o
);

    logic [31:0] shifted_s;

    // Replicate the right-justified write value onto every lane it could land in
    always_comb begin
        case (size_i)
            HSIZE_BYTE: wdata_o = {4{wdata_i[7:0]}};
            HSIZE_HALF: wdata_o = {2{wdata_i[15:0]}};
            default:    wdata_o = wdata_i;
        endcase
    end

    // Bring the addressed lane down to bit 0 and zero-extend to the access size
    always_comb begin
        shifted_s = rdata_i >> {addr_lo_i, 3'b000};
        case (size_i)
            HSIZE_BYTE: rdata_o = {24'h00_0000, shifted_s[7:0]};
            HSIZE_HALF: rdata_o = {16'h0000, shifted_s[15:0]};
            default:    rdata_o = shifted_s;
        endcase
    end

    // Flag sizes above a word and accesses not aligned to their own size
    always_comb begin
        case (size_i)
            HSIZE_BYTE: bad_o = 1'b0;
            HSIZE_HALF: bad_o = addr_lo_i[0];
            HSIZE_WORD: bad_o = (addr_lo_i != 2'b00);
            default:    bad_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_burst_master.sv
// Data-side bus initiator: serves single byte/half/word accesses and
// BLOCK_WORDS-word cache fills/writebacks on the AHB-style memory port.
// Bus outputs are decoded from registered state, so a low Valid (wait state)
// leaves every bus output unchanged.
module ahb_burst_master
    import leg_bus_pkg::*;
#(
    parameter int BLOCK_WORDS = BLOCK_WORDS_DFLT,
    parameter int ADDR_W      = 32
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_write,
    input  logic                           req_block,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [2:0]                     req_size,
    input  logic [31:0]                    req_wdata,
    output logic [$clog2(BLOCK_WORDS)-1:0] wb_idx,
    input  logic [31:0]                    wb_data,
    output logic                           fill_we,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_idx,
    output logic [31:0]                    fill_data,
    output logic                           rsp_valid,
    output logic [31:0]                    rsp_rdata,
    output logic                           rsp_err,
    output logic                           HSEL,
    output logic                           we,
    output logic                           re,
    output logic [ADDR_W-1:0]              HADDR,
    output logic [31:0]                    HWDATA,
    output logic [2:0]                     HSIZE,
    input  logic [31:0]                    HRDATA,
    input  logic                           Valid
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W = IDX_W + 2;

    mst_state_e         state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [2:0]         size_q, size_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               write_q, write_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [2:0]         la_size_s;
    logic [1:0]         la_addr_s;
    logic [31:0]        la_wdata_s;
    logic [31:0]        la_rdata_s;
    logic               la_bad_s;
    logic               accept_s;
    logic               in_burst_s;
    logic               last_beat_s;
    logic [ADDR_W-1:0]  beat_addr_s;

    assign accept_s    = req_valid && (state_q == ST_IDLE);
    assign in_burst_s  = (state_q == ST_BURST_RD) || (state_q == ST_BURST_WR);
    assign last_beat_s = (cnt_q == IDX_W'(BLOCK_WORDS - 1));
    // Block base with the word counter spliced into the offset field
    assign beat_addr_s = {addr_q[ADDR_W-1:OFF_W], cnt_q, 2'b00};
    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_rdata   = rdata_q;

    // While idle the aligner judges the incoming request; otherwise it serves the registered one
    always_comb begin
        if (state_q == ST_IDLE) begin
            la_size_s = req_size;
            la_addr_s = req_addr[1:0];
        end else begin
            la_size_s = size_q;
            la_addr_s = addr_q[1:0];
        end
    end

    lane_align u_lane_align (
        .size_i    (la_size_s),
        .addr_lo_i (la_addr_s),
        .wdata_i   (req_wdata),
        .rdata_i   (HRDATA),
        .wdata_o   (la_wdata_s),
        .rdata_o   (la_rdata_s),
        .bad_o     (la_bad_s)
    );

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: rejected singles skip the bus and go straight to the response
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_block) begin
                        state_d = req_write ? ST_BURST_WR : ST_BURST_RD;
                    end else if (la_bad_s) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_SINGLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SINGLE: begin
                if (Valid) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_SINGLE;
                end
            end
            ST_BURST_RD, ST_BURST_WR: begin
                if (Valid && last_beat_s) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture, beat counting and single-read result capture
    always_comb begin
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        write_d = write_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        if (accept_s) begin
            addr_d  = req_addr;
            size_d  = req_size;
            wdata_d = la_wdata_s;
            write_d = req_write;
            err_d   = !req_block && la_bad_s;
            cnt_d   = {IDX_W{1'b0}};
        end else if (in_burst_s && Valid) begin
            // Free-running wrap brings the counter back to zero after the last beat
            cnt_d = cnt_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if ((state_q == ST_SINGLE) && Valid && !write_q) begin
            rdata_d = la_rdata_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= {IDX_W{1'b0}};
            addr_q  <= {ADDR_W{1'b0}};
            size_q  <= 3'b000;
            wdata_q <= 32'h0000_0000;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Output decode from the current state; everything idles at zero
    always_comb begin
        HSEL      = 1'b0;
        we        = 1'b0;
        re        = 1'b0;
        HADDR     = {ADDR_W{1'b0}};
        HWDATA    = 32'h0000_0000;
        HSIZE     = HSIZE_BYTE;
        wb_idx    = {IDX_W{1'b0}};
        fill_we   = 1'b0;
        fill_idx  = {IDX_W{1'b0}};
        fill_data = 32'h0000_0000;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        case (state_q)
            ST_SINGLE: begin
                HSEL   = 1'b1;
                we     = write_q;
                re     = !write_q;
                HADDR  = addr_q;
                HWDATA = write_q ? wdata_q : 32'h0000_0000;
                HSIZE  = size_q;
            end
            ST_BURST_RD: begin
                HSEL      = 1'b1;
                re        = 1'b1;
                HADDR     = beat_addr_s;
                HSIZE     = HSIZE_WORD;
                fill_we   = Valid;
                fill_idx  = cnt_q;
                fill_data = HRDATA;
            end
            ST_BURST_WR: begin
                HSEL   = 1'b1;
                we     = 1'b1;
                HADDR  = beat_addr_s;
                HWDATA = wb_data;
                HSIZE  = HSIZE_WORD;
                wb_idx = cnt_q;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
            end
            default: begin
                HSEL = 1'b0;
            end
        endcase
    end

endmodule
